// File: rtl/axi_slv_mem.sv
// axi_slv_mem: AXI4 slave backed by on-chip word storage.
//
// Independent write and read FSMs. Each accepts one burst at a time and
// supports FIXED, INCR and WRAP bursts with narrow transfer sizes.
// Beats that fall outside the storage, and bursts with an illegal
// configuration, get a SLVERR response.
//
// Ports
//   ACLK, ARESETn                      clock, async active-low reset
//   AW*  (AWREADY out)                 write address channel
//   W*   (WREADY out, WID ignored)     write data channel
//   B*   (BID/BRESP/BVALID out)        write response channel
//   AR*  (ARREADY out)                 read address channel
//   R*   (RID/RDATA/RRESP/RLAST/RVALID out) read data channel
// AWPROT and ARPROT are accepted but have no effect.
module axi_slv_mem #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned MEM_DEPTH  = 256
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  // write address
  input  logic [ID_WIDTH-1:0]     AWID,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [7:0]              AWLEN,
  input  logic [2:0]              AWSIZE,
  input  logic [1:0]              AWBURST,
  input  logic [2:0]              AWPROT,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  // write data
  input  logic [ID_WIDTH-1:0]     WID,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WLAST,
  input  logic                    WVALID,
  output logic                    WREADY,
  // write response
  output logic [ID_WIDTH-1:0]     BID,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  // read address
  input  logic [ID_WIDTH-1:0]     ARID,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic [7:0]              ARLEN,
  input  logic [2:0]              ARSIZE,
  input  logic [1:0]              ARBURST,
  input  logic [2:0]              ARPROT,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  // read data
  output logic [ID_WIDTH-1:0]     RID,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RLAST,
  output logic                    RVALID,
  input  logic                    RREADY
);

  localparam int unsigned STRB_W   = DATA_WIDTH / 8;
  localparam int unsigned BYTE_LSB = $clog2(STRB_W);
  localparam int unsigned IDX_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [2:0]  MAX_SIZE = 3'(BYTE_LSB);
  localparam logic [1:0]  RESP_OK  = 2'b00;
  localparam logic [1:0]  RESP_SLV = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_e;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Address of the beat following addr. WRAP keeps the upper bits of the
  // aligned (LEN+1)*step block and lets only the in-block offset advance.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [2:0]            size,
    input logic [7:0]            len,
    input logic [1:0]            burst
  );
    logic [ADDR_WIDTH-1:0] incr;
    logic [ADDR_WIDTH-1:0] mask;
    incr = addr + (ADDR_WIDTH'(1) << size);
    mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    case (burst)
      2'b00:   next_addr = addr;
      2'b10:   next_addr = (addr & ~mask) | (incr & mask);
      default: next_addr = incr;
    endcase
  endfunction

  // Burst-wide configuration errors, known as soon as the address arrives.
  function automatic logic cfg_err(
    input logic [2:0] size,
    input logic [7:0] len,
    input logic [1:0] burst
  );
    logic wrap_len_ok;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    cfg_err = (burst == 2'b11) || (size > MAX_SIZE) || ((burst == 2'b10) && !wrap_len_ok);
  endfunction

  function automatic logic idx_err(input logic [ADDR_WIDTH-1:0] addr);
    idx_err = (addr >> BYTE_LSB) >= ADDR_WIDTH'(MEM_DEPTH);
  endfunction

  // ---------------------------------------------------------------- write
  wstate_e               wstate_q, wstate_d;
  logic [ID_WIDTH-1:0]   awid_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [7:0]            wlen_q;
  logic [2:0]            wsize_q;
  logic [1:0]            wburst_q;
  logic [7:0]            wcnt_q;
  logic                  wcfg_err_q;
  logic                  werr_q;

  logic                  aw_hs, w_hs, b_hs, wlast_beat, wbeat_err;
  logic [ADDR_WIDTH-1:0] wword;
  logic [IDX_W-1:0]      widx;

  assign aw_hs      = AWVALID & AWREADY;
  assign w_hs       = WVALID & WREADY;
  assign b_hs       = BVALID & BREADY;
  assign wlast_beat = (wcnt_q == wlen_q);
  assign wbeat_err  = wcfg_err_q | idx_err(waddr_q);
  assign wword      = waddr_q >> BYTE_LSB;
  assign widx       = wword[IDX_W-1:0];

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) wstate_q <= W_IDLE;
    else          wstate_q <= wstate_d;
  end

  always_comb begin
    wstate_d = wstate_q;
    case (wstate_q)
      W_IDLE:  if (aw_hs)              wstate_d = W_DATA;
      W_DATA:  if (w_hs && wlast_beat) wstate_d = W_RESP;
      W_RESP:  if (b_hs)               wstate_d = W_IDLE;
      default:                         wstate_d = W_IDLE;
    endcase
  end

  always_comb begin
    AWREADY = (wstate_q == W_IDLE);
    WREADY  = (wstate_q == W_DATA);
    BVALID  = (wstate_q == W_RESP);
    BID     = awid_q;
    BRESP   = werr_q ? RESP_SLV : RESP_OK;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      awid_q     <= '0;
      waddr_q    <= '0;
      wlen_q     <= '0;
      wsize_q    <= '0;
      wburst_q   <= '0;
      wcnt_q     <= '0;
      wcfg_err_q <= 1'b0;
      werr_q     <= 1'b0;
    end else if (aw_hs) begin
      awid_q     <= AWID;
      waddr_q    <= AWADDR;
      wlen_q     <= AWLEN;
      wsize_q    <= AWSIZE;
      wburst_q   <= AWBURST;
      wcnt_q     <= '0;
      wcfg_err_q <= cfg_err(AWSIZE, AWLEN, AWBURST);
      werr_q     <= 1'b0;
    end else if (w_hs) begin
      // Sticky: any errored beat or a WLAST that disagrees with the count.
      werr_q  <= werr_q | wbeat_err | (WLAST != wlast_beat);
      wcnt_q  <= wcnt_q + 8'd1;
      waddr_q <= next_addr(waddr_q, wsize_q, wlen_q, wburst_q);
    end
  end

  always_ff @(posedge ACLK) begin
    if (w_hs && !wbeat_err) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (WSTRB[b]) mem[widx][8*b +: 8] <= WDATA[8*b +: 8];
      end
    end
  end

  // ----------------------------------------------------------------- read
  rstate_e               rstate_q, rstate_d;
  logic [ID_WIDTH-1:0]   rid_q;
  logic [ADDR_WIDTH-1:0] raddr_q;
  logic [7:0]            rlen_q;
  logic [2:0]            rsize_q;
  logic [1:0]            rburst_q;
  logic [7:0]            rcnt_q;
  logic                  rcfg_err_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;

  logic                  ar_hs, r_hs, rlast_beat, rd_load, rd_cfg, rd_err;
  logic [ADDR_WIDTH-1:0] rd_addr, rword;
  logic [IDX_W-1:0]      ridx;

  assign ar_hs      = ARVALID & ARREADY;
  assign r_hs       = RVALID & RREADY;
  assign rlast_beat = (rstate_q == R_DATA) && (rcnt_q == rlen_q);

  // RDATA is registered, so the word for the next beat is fetched on the
  // edge that accepts the current one (or the AR handshake for beat 0).
  // Because the fetch and any write share an edge, a same-word collision
  // naturally returns the pre-write contents.
  assign rd_load = ar_hs | (r_hs & ~rlast_beat);
  assign rd_addr = (rstate_q == R_IDLE) ? ARADDR
                                        : next_addr(raddr_q, rsize_q, rlen_q, rburst_q);
  assign rd_cfg  = (rstate_q == R_IDLE) ? cfg_err(ARSIZE, ARLEN, ARBURST) : rcfg_err_q;
  assign rd_err  = rd_cfg | idx_err(rd_addr);
  assign rword   = rd_addr >> BYTE_LSB;
  assign ridx    = rword[IDX_W-1:0];

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) rstate_q <= R_IDLE;
    else          rstate_q <= rstate_d;
  end

  always_comb begin
    rstate_d = rstate_q;
    case (rstate_q)
      R_IDLE:  if (ar_hs)              rstate_d = R_DATA;
      R_DATA:  if (r_hs && rlast_beat) rstate_d = R_IDLE;
      default:                         rstate_d = R_IDLE;
    endcase
  end

  always_comb begin
    ARREADY = (rstate_q == R_IDLE);
    RVALID  = (rstate_q == R_DATA);
    RLAST   = rlast_beat;
    RID     = rid_q;
    RDATA   = rdata_q;
    RRESP   = rresp_q;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rid_q      <= '0;
      raddr_q    <= '0;
      rlen_q     <= '0;
      rsize_q    <= '0;
      rburst_q   <= '0;
      rcnt_q     <= '0;
      rcfg_err_q <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= '0;
    end else begin
      if (ar_hs) begin
        rid_q      <= ARID;
        rlen_q     <= ARLEN;
        rsize_q    <= ARSIZE;
        rburst_q   <= ARBURST;
        rcfg_err_q <= rd_cfg;
        rcnt_q     <= '0;
      end else if (r_hs && !rlast_beat) begin
        rcnt_q <= rcnt_q + 8'd1;
      end
      if (rd_load) begin
        raddr_q <= rd_addr;
        rdata_q <= rd_err ? '0 : mem[ridx];
        rresp_q <= rd_err ? RESP_SLV : RESP_OK;
      end
    end
  end

  logic unused_inputs;
  assign unused_inputs = ^{WID, AWPROT, ARPROT, wword, rword};

endmodule

// File: tb/tb_axi_slv_mem.sv
module tb_axi_slv_mem;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [3:0]  AWID, WID, BID, ARID, RID;
  logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
  logic [7:0]  AWLEN, ARLEN;
  logic [2:0]  AWSIZE, ARSIZE, AWPROT, ARPROT;
  logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
  logic [3:0]  WSTRB;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

  always #5 ACLK = ~ACLK;

  axi_slv_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .MEM_DEPTH(256)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic        chk;
  } rexp_t;

  rexp_t       sb[$];
  logic [31:0] model [256];
  bit          known [256];
  int          n_checks = 0;
  int          n_fail   = 0;

  // Address of beat i of a burst, computed directly from the beat number.
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [2:0] size,
                                            input logic [7:0] len, input logic [1:0] burst,
                                            input int i);
    logic [31:0] step, blk, base;
    step = 32'd1 << size;
    blk  = (32'(len) + 32'd1) * step;
    base = (a / blk) * blk;
    case (burst)
      2'b00:   return a;
      2'b10:   return base + (((a - base) + 32'(i) * step) % blk);
      default: return a + 32'(i) * step;
    endcase
  endfunction

  function automatic bit beat_bad(input logic [31:0] a, input logic [2:0] size,
                                  input logic [7:0] len, input logic [1:0] burst);
    bit wrap_bad;
    wrap_bad = (burst == 2'b10) && !(len == 1 || len == 3 || len == 7 || len == 15);
    return (burst == 2'b11) || (size > 3'd2) || wrap_bad || ((a >> 2) >= 32'd256);
  endfunction

  task automatic wait_sig(input string name, ref logic sig);
    int n = 0;
    while (sig !== 1'b1 && n < 50) begin @(negedge ACLK); n++; end
    if (sig !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL %s: timeout waiting, got %b required 1", name, sig);
    end
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic [3:0] strb,
                          input logic [31:0] d0, input int bready_delay);
    logic [1:0] exp_resp = 2'b00;
    @(negedge ACLK);
    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
    wait_sig("aw_ready", AWREADY);
    @(negedge ACLK);
    AWVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      logic [31:0] a;
      a = beat_addr(addr, size, len, burst, i);
      WDATA = d0 + 32'(i); WSTRB = strb; WLAST = (i == int'(len)); WVALID = 1'b1;
      wait_sig("w_ready", WREADY);
      if (beat_bad(a, size, len, burst)) exp_resp = 2'b10;
      else begin
        for (int b = 0; b < 4; b++)
          if (strb[b]) model[a >> 2][8*b +: 8] = WDATA[8*b +: 8];
        if (strb == 4'hF) known[a >> 2] = 1'b1;
      end
      @(negedge ACLK);
    end
    WVALID = 1'b0; WLAST = 1'b0;
    wait_sig("b_valid", BVALID);
    n_checks++;
    if (BID !== id || BRESP !== exp_resp) begin
      n_fail++;
      $display("FAIL b_resp: got id=%h resp=%b required id=%h resp=%b", BID, BRESP, id, exp_resp);
    end
    for (int k = 0; k < bready_delay; k++) begin
      @(negedge ACLK);
      n_checks++;
      if (BVALID !== 1'b1 || BRESP !== exp_resp) begin
        n_fail++;
        $display("FAIL b_hold: got valid=%b resp=%b required valid=1 resp=%b", BVALID, BRESP, exp_resp);
      end
    end
    BREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0;
    n_checks++;
    if (BVALID !== 1'b0) begin
      n_fail++;
      $display("FAIL b_done: got bvalid=%b required 0", BVALID);
    end
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input int stall_beat);
    for (int i = 0; i <= int'(len); i++) begin
      rexp_t e;
      logic [31:0] a;
      a = beat_addr(addr, size, len, burst, i);
      if (beat_bad(a, size, len, burst)) begin
        e.data = 32'd0; e.resp = 2'b10; e.chk = 1'b1;
      end else begin
        e.data = model[a >> 2]; e.resp = 2'b00; e.chk = known[a >> 2];
      end
      e.last = (i == int'(len));
      sb.push_back(e);
    end
    @(negedge ACLK);
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
    wait_sig("ar_ready", ARREADY);
    @(negedge ACLK);
    ARVALID = 1'b0;
    n_checks++;
    if (RVALID !== 1'b1) begin
      n_fail++;
      $display("FAIL r_first_latency: got rvalid=%b required 1", RVALID);
    end
    for (int i = 0; i <= int'(len); i++) begin
      rexp_t e;
      wait_sig("r_valid", RVALID);
      e = sb.pop_front();
      n_checks++;
      if ((e.chk && RDATA !== e.data) || RRESP !== e.resp || RLAST !== e.last || RID !== id) begin
        n_fail++;
        $display("FAIL r_beat%0d: got data=%h resp=%b last=%b id=%h required data=%h(chk=%b) resp=%b last=%b id=%h",
                 i, RDATA, RRESP, RLAST, RID, e.data, e.chk, e.resp, e.last, id);
      end
      if (i == stall_beat) begin
        logic [38:0] snap;
        snap = {RDATA, RID, RRESP, RLAST};
        for (int k = 0; k < 5; k++) begin
          @(negedge ACLK);
          n_checks++;
          if (RVALID !== 1'b1 || {RDATA, RID, RRESP, RLAST} !== snap) begin
            n_fail++;
            $display("FAIL r_stall: got valid=%b bus=%h required valid=1 bus=%h",
                     RVALID, {RDATA, RID, RRESP, RLAST}, snap);
          end
        end
      end
      RREADY = 1'b1;
      @(negedge ACLK);
      RREADY = 1'b0;
    end
    n_checks++;
    if (RVALID !== 1'b0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL r_done: got rvalid=%b pending=%0d required rvalid=0 pending=0", RVALID, sb.size());
    end
  endtask

  task automatic check_reset_outputs(input string name);
    n_checks++;
    if ({AWREADY, ARREADY, WREADY, BVALID, RVALID, RLAST} !== 6'b110000) begin
      n_fail++;
      $display("FAIL %s_ctrl: got %b required 110000", name,
               {AWREADY, ARREADY, WREADY, BVALID, RVALID, RLAST});
    end
    n_checks++;
    if ({BID, RID, BRESP, RRESP, RDATA} !== '0) begin
      n_fail++;
      $display("FAIL %s_data: got bid=%h rid=%h bresp=%b rresp=%b rdata=%h required all 0",
               name, BID, RID, BRESP, RRESP, RDATA);
    end
  endtask

  task automatic test_reset();
    ARESETn = 1'b0;
    repeat (3) @(negedge ACLK);
    check_reset_outputs("reset");
    ARESETn = 1'b1;
  endtask

  task automatic test_incr();
    do_write(4'h3, 32'h10, 8'd3, 3'd2, 2'b01, 4'hF, 32'hA0, 0);
    do_read(4'h5, 32'h10, 8'd3, 3'd2, 2'b01, -1);
  endtask

  task automatic test_wrap();
    // words 4..7 hold A0..A3, expected order 6,7,4,5
    do_read(4'h6, 32'h18, 8'd3, 3'd2, 2'b10, -1);
    do_read(4'h7, 32'h14, 8'd0, 3'd2, 2'b00, -1);
    do_read(4'h8, 32'h10, 8'd2, 3'd2, 2'b00, -1);
  endtask

  task automatic test_strobe();
    do_write(4'h1, 32'h20, 8'd0, 3'd2, 2'b01, 4'hF, 32'h11223344, 0);
    do_write(4'h2, 32'h20, 8'd0, 3'd2, 2'b01, 4'h3, 32'hDEADBEEF, 0);
    do_read(4'h1, 32'h20, 8'd0, 3'd2, 2'b01, -1);
  endtask

  task automatic test_out_of_range();
    do_write(4'h4, 32'h0, 8'd0, 3'd2, 2'b01, 4'hF, 32'h5A5A0000, 0);
    do_write(4'h9, 32'h400, 8'd0, 3'd2, 2'b01, 4'hF, 32'hBAD0BAD0, 0);
    do_read(4'h9, 32'h400, 8'd0, 3'd2, 2'b01, -1);
    do_read(4'hA, 32'h0, 8'd0, 3'd2, 2'b01, -1);
    do_write(4'hB, 32'h3F8, 8'd1, 3'd2, 2'b01, 4'hF, 32'h00FE0000, 0);
    do_read(4'hB, 32'h3F8, 8'd3, 3'd2, 2'b01, -1);
  endtask

  task automatic test_bad_config();
    do_write(4'hC, 32'h0, 8'd1, 3'd2, 2'b11, 4'hF, 32'hCAFE0000, 0);
    do_read(4'hC, 32'h10, 8'd2, 3'd2, 2'b10, -1);
    do_read(4'hD, 32'h10, 8'd0, 3'd3, 2'b01, -1);
    do_read(4'hE, 32'h0, 8'd0, 3'd2, 2'b01, -1);
  endtask

  task automatic test_backpressure();
    do_write(4'hF, 32'h80, 8'd3, 3'd2, 2'b01, 4'hF, 32'h77770000, 4);
    do_read(4'h2, 32'h80, 8'd3, 3'd2, 2'b01, 1);
  endtask

  task automatic test_reset_mid_burst();
    @(negedge ACLK);
    AWID = 4'h6; AWADDR = 32'h40; AWLEN = 8'd7; AWSIZE = 3'd2; AWBURST = 2'b01; AWVALID = 1'b1;
    wait_sig("aw_ready", AWREADY);
    @(negedge ACLK);
    AWVALID = 1'b0;
    for (int i = 0; i < 2; i++) begin
      WDATA = 32'h99990000 + 32'(i); WSTRB = 4'hF; WLAST = 1'b0; WVALID = 1'b1;
      wait_sig("w_ready", WREADY);
      model[16 + i] = WDATA; known[16 + i] = 1'b1;
      @(negedge ACLK);
    end
    WDATA = 32'h99990002;
    #1 ARESETn = 1'b0;
    #1 check_reset_outputs("mid_reset");
    @(negedge ACLK);
    WVALID = 1'b0;
    ARESETn = 1'b1;
    BREADY = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge ACLK);
      n_checks++;
      if (BVALID !== 1'b0 || WREADY !== 1'b0 || AWREADY !== 1'b1) begin
        n_fail++;
        $display("FAIL post_reset_idle: got bvalid=%b wready=%b awready=%b required 0 0 1",
                 BVALID, WREADY, AWREADY);
      end
    end
    BREADY = 1'b0;
    do_write(4'h7, 32'h40, 8'd7, 3'd2, 2'b01, 4'hF, 32'h12340000, 0);
    do_read(4'h7, 32'h40, 8'd7, 3'd2, 2'b01, -1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin model[i] = 32'd0; known[i] = 1'b0; end
    AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWPROT = 3'b010; AWVALID = 1'b0;
    WID = '0; WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARPROT = 3'b101; ARVALID = 1'b0;
    RREADY = 1'b0;
    test_reset();
    test_incr();
    test_wrap();
    test_strobe();
    test_out_of_range();
    test_bad_config();
    test_backpressure();
    test_reset_mid_burst();
    repeat (2) @(negedge ACLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
